// File: rtl/time_bcd_counter.sv
// HH:MM:SS BCD time-of-day counter with 1 Hz prescaler and button-driven set mode.
// Optional 12-hour display with PM flag when TWELVE_HOUR_EN is defined.
module time_bcd_counter #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] h1,
   output logic [3:0] h0,
   output logic [3:0] m1,
   output logic [3:0] m0,
   output logic [3:0] s1,
   output logic [3:0] s0,
   output logic [1:0] set_mode,
   output logic       tick
`ifdef TWELVE_HOUR_EN
   ,
   output logic       pm
`endif
);

   localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

`ifdef TWELVE_HOUR_EN
   localparam logic [7:0] HH_RST = 8'h12;
`else
   localparam logic [7:0] HH_RST = 8'h00;
`endif

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      SET_H = 2'b01,
      SET_M = 2'b10,
      SET_S = 2'b11
   } mode_t;

   mode_t         state;
   logic [CW-1:0] cnt;
   logic          mode_q;
   logic          inc_q;
   logic [7:0]    hh;
   logic [7:0]    mm;
   logic [7:0]    ss;
   logic          wrap;
   logic          mode_rise;
   logic          inc_rise;

   function automatic logic [7:0] inc60(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] hour_next(input logic [7:0] v);
`ifdef TWELVE_HOUR_EN
      if (v == 8'h12) return 8'h01;
`else
      if (v == 8'h23) return 8'h00;
`endif
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign wrap      = (cnt == LAST);
   assign mode_rise = btn_mode & ~mode_q;
   assign inc_rise  = btn_inc & ~inc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         cnt    <= '0;
         tick   <= 1'b0;
         mode_q <= 1'b0;
         inc_q  <= 1'b0;
         hh     <= HH_RST;
         mm     <= 8'h00;
         ss     <= 8'h00;
`ifdef TWELVE_HOUR_EN
         pm     <= 1'b0;
`endif
      end else begin
         mode_q <= btn_mode;
         inc_q  <= btn_inc;
         tick   <= wrap;
         cnt    <= wrap ? '0 : cnt + CW'(1);
         case (state)
            RUN: begin
               // A tick landing on the mode press still advances time before freezing.
               if (wrap) begin
                  if (ss == 8'h59) begin
                     ss <= 8'h00;
                     if (mm == 8'h59) begin
                        mm <= 8'h00;
                        hh <= hour_next(hh);
`ifdef TWELVE_HOUR_EN
                        if (hh == 8'h11) pm <= ~pm;
`endif
                     end else begin
                        mm <= inc60(mm);
                     end
                  end else begin
                     ss <= inc60(ss);
                  end
               end
               if (mode_rise) state <= SET_H;
            end
            SET_H: begin
               if (mode_rise) begin
                  state <= SET_M;
               end else if (inc_rise) begin
                  hh <= hour_next(hh);
`ifdef TWELVE_HOUR_EN
                  if (hh == 8'h11) pm <= ~pm;
`endif
               end
            end
            SET_M: begin
               if (mode_rise)     state <= SET_S;
               else if (inc_rise) mm    <= inc60(mm);
            end
            SET_S: begin
               // Restart the second so the first run increment is a full period away.
               if (mode_rise) begin
                  state <= RUN;
                  cnt   <= '0;
               end else if (inc_rise) begin
                  ss <= inc60(ss);
               end
            end
         endcase
      end
   end

   assign set_mode = state;
   assign h1 = hh[7:4];
   assign h0 = hh[3:0];
   assign m1 = mm[7:4];
   assign m0 = mm[3:0];
   assign s1 = ss[7:4];
   assign s0 = ss[3:0];

endmodule

// File: tb/tb_time_bcd_counter.sv
// Directed bench for time_bcd_counter (TICK_DIV=4); expectations queued and checked in order.
module tb_time_bcd_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode;
   logic       btn_inc;
   logic [3:0] h1, h0, m1, m0, s1, s0;
   logic [1:0] set_mode;
   logic       tick;
`ifdef TWELVE_HOUR_EN
   logic       pm;
`endif

   time_bcd_counter #(.TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
      .set_mode(set_mode), .tick(tick)
`ifdef TWELVE_HOUR_EN
      , .pm(pm)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [26:0] exp;
      logic [26:0] mask;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [26:0] M_ALL  = '1;
   localparam logic [26:0] M_TM   = {24'hFFFFFF, 2'b11, 1'b0};
   localparam logic [26:0] M_MODE = {24'h000000, 2'b11, 1'b0};

   function automatic logic [26:0] snap();
      return {h1, h0, m1, m0, s1, s0, set_mode, tick};
   endfunction

   function automatic logic [26:0] mk(input logic [23:0] t, input logic [1:0] m, input logic tk);
      return {t, m, tk};
   endfunction

   task automatic expect_val(input string tag, input logic [26:0] e, input logic [26:0] m);
      exp_t x;
      x.tag = tag; x.exp = e; x.mask = m;
      sb.push_back(x);
   endtask

   task automatic compare(input logic [26:0] obs);
      exp_t x;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed=%h", obs);
      end else begin
         x = sb.pop_front();
         assert ((obs & x.mask) === (x.exp & x.mask)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", x.tag, obs & x.mask, x.exp & x.mask);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_mode();
      btn_mode = 1'b1; step(1);
      btn_mode = 1'b0; step(1);
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         btn_inc = 1'b1; step(1);
         btn_inc = 1'b0; step(1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; step(1);
      rst = 1'b0;
   endtask

   initial begin
      int tick_cnt;
      rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      step(1);
`ifndef TWELVE_HOUR_EN
      // 1: reset state, two ticks in eight cycles
      expect_val("reset_state", mk(24'h000000, 2'b00, 1'b0), M_ALL);
      do_reset();
      compare(snap());
      expect_val("tick_count_8cyc", 27'(2), M_ALL);
      expect_val("run_8cyc", mk(24'h000002, 2'b00, 1'b1), M_ALL);
      tick_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (tick) tick_cnt++;
      end
      compare(27'(tick_cnt));
      compare(snap());

      // 2: preload 23:59:58, full rollover
      do_reset();
      press_mode(); press_inc(23);
      press_mode(); press_inc(59);
      press_mode(); press_inc(58);
      expect_val("preload", mk(24'h235958, 2'b11, 1'b0), M_TM);
      compare(snap());
      press_mode();
      step(2);
      expect_val("no_early_tick", mk(24'h235958, 2'b00, 1'b0), M_ALL);
      compare(snap());
      step(1);
      expect_val("first_tick", mk(24'h235959, 2'b00, 1'b1), M_ALL);
      compare(snap());
      step(4);
      expect_val("full_wrap", mk(24'h000000, 2'b00, 1'b1), M_ALL);
      compare(snap());

      // 3: hours wrap mod 24 in SET_H
      press_mode(); press_inc(25);
      expect_val("set_h_25", mk(24'h010000, 2'b01, 1'b0), M_TM);
      compare(snap());

      // 4: held inc is one event; simultaneous mode+inc favours mode
      press_mode();
      btn_inc = 1'b1; step(10);
      btn_inc = 1'b0; step(1);
      expect_val("inc_held", mk(24'h010100, 2'b10, 1'b0), M_TM);
      compare(snap());
      btn_mode = 1'b1; btn_inc = 1'b1; step(1);
      expect_val("mode_wins", mk(24'h010100, 2'b11, 1'b0), M_TM);
      compare(snap());
      btn_mode = 1'b0; btn_inc = 1'b0; step(1);

      // 5: set 12:34:56, seconds wrap without carry, reset mid-set
      press_mode(); press_mode();
      press_inc(11);
      press_mode(); press_inc(33);
      press_mode(); press_inc(56);
      expect_val("set_123456", mk(24'h123456, 2'b11, 1'b0), M_TM);
      compare(snap());
      press_inc(4);
      expect_val("sec_no_carry", mk(24'h123400, 2'b11, 1'b0), M_TM);
      compare(snap());
      expect_val("reset_mid_set", mk(24'h000000, 2'b00, 1'b0), M_ALL);
      do_reset();
      compare(snap());

      // tick coinciding with RUN->SET_H still advances; SET_H freezes time
      step(3);
      btn_mode = 1'b1; step(1);
      expect_val("tick_on_mode", mk(24'h000001, 2'b01, 1'b1), M_ALL);
      compare(snap());
      btn_mode = 1'b0; step(8);
      expect_val("set_frozen", mk(24'h000001, 2'b01, 1'b0), M_TM);
      compare(snap());
      expect_val("mode_only", mk(24'h000000, 2'b01, 1'b0), M_MODE);
      compare(snap());
`else
      // 6: 12-hour mode
      expect_val("reset_12h", mk(24'h120000, 2'b00, 1'b0), M_ALL);
      expect_val("reset_pm", 27'(0), M_ALL);
      do_reset();
      compare(snap());
      compare(27'(pm));
      press_mode(); press_inc(11);
      press_mode(); press_inc(59);
      press_mode(); press_inc(59);
      press_mode();
      step(2);
      expect_val("pre_noon", mk(24'h115959, 2'b00, 1'b0), M_ALL);
      expect_val("pre_noon_pm", 27'(0), M_ALL);
      compare(snap());
      compare(27'(pm));
      step(1);
      expect_val("noon", mk(24'h120000, 2'b00, 1'b1), M_ALL);
      expect_val("noon_pm", 27'(1), M_ALL);
      compare(snap());
      compare(27'(pm));
      press_mode(); press_inc(1);
      expect_val("set_h_12_01", mk(24'h010000, 2'b01, 1'b0), M_TM);
      expect_val("pm_kept", 27'(1), M_ALL);
      compare(snap());
      compare(27'(pm));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
